// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SERIAL_ADDER_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full-adder cell used by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned W-bit adder, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by SERIAL_ADDER_SIGNED_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned W = SERIAL_ADDER_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry_out
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t         state, state_next;
  logic [W-1:0]   a_sr, b_sr;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           fa_s, fa_cout;
  logic           in_fire, out_fire, last_bit;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_bit = (cnt == CNT_LAST);

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_fire)  state_next = CALC;
      CALC:    if (last_bit) state_next = DONE;
      DONE:    if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Sum bits enter at the MSB; after W shifts the first bit lands in sum[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        CALC: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= {fa_s, sum[W-1:1]};
          carry <= fa_cout;
          if (last_bit) begin
            cnt       <= '0;
            carry_out <= fa_cout;
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
            ovf       <= carry ^ fa_cout;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table plus directed handshake/reset sequences.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  serial_adder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, W);
  endtask

  // One full transaction: accept, wait for result, check, take it.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                        input logic [W-1:0] es, input logic ec, input string tag);
    int n;
    int lat;
    logic [W:0] model;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready before"}, in_ready, 1);
    a = ta;
    b = tb_b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check({tag, " in_ready busy"}, in_ready, 0);
    wait_out(tag, lat);
    model = {1'b0, ta} + {1'b0, tb_b};
    check({tag, " sum"}, sum, es);
    check({tag, " carry_out"}, carry_out, ec);
    check({tag, " model"}, {carry_out, sum}, model);
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
    check({tag, " ovf"}, ovf, (ta[W-1] == tb_b[W-1]) && (es[W-1] != ta[W-1]));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " in_ready after"}, in_ready, 1);
    check({tag, " out_valid after"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_sum;
    logic         held_c;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   s: 8'd8,   c: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   s: 8'd0,   c: 1'b1};
    vecs[2] = '{a: 8'd255, b: 8'd255, s: 8'd254, c: 1'b1};
    vecs[3] = '{a: 8'd0,   b: 8'd0,   s: 8'd0,   c: 1'b0};
    vecs[4] = '{a: 8'd128, b: 8'd128, s: 8'd0,   c: 1'b1};
    vecs[5] = '{a: 8'd170, b: 8'd85,  s: 8'd255, c: 1'b0};
    vecs[6] = '{a: 8'd127, b: 8'd1,   s: 8'd128, c: 1'b0};
    vecs[7] = '{a: 8'd99,  b: 8'd200, s: 8'd43,  c: 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset carry_out", carry_out, 0);
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

    // Back-pressure: result must hold while out_ready is low; new in_valid ignored.
    a = 8'd100;
    b = 8'd27;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out("bp", lat);
    check("bp sum", sum, 127);
    check("bp carry_out", carry_out, 0);
    held_sum = sum;
    held_c = carry_out;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      a = 8'd1;
      b = 8'd1;
      tick();
      check("bp out_valid held", out_valid, 1);
      check("bp in_ready low", in_ready, 0);
      check("bp sum held", sum, held_sum);
      check("bp carry held", carry_out, held_c);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp idle in_ready", in_ready, 1);
    tick();
    check("bp no capture", in_ready, 1);
    check("bp no out_valid", out_valid, 0);

    // Back-to-back with in_valid held high and out_ready high.
    a = 8'd10;
    b = 8'd20;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    check("b2b first accept", in_ready, 0);
    a = 8'd200;
    b = 8'd100;
    wait_out("b2b first", lat);
    check("b2b first sum", sum, 30);
    check("b2b first carry", carry_out, 0);
    tick();
    check("b2b idle gap in_ready", in_ready, 1);
    check("b2b idle gap out_valid", out_valid, 0);
    tick();
    check("b2b second accept", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_out("b2b second", lat);
    check("b2b second sum", sum, 44);
    check("b2b second carry", carry_out, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-CALC; carry_out is 1 from the previous result.
    a = 8'd7;
    b = 8'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("midcalc busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("rst async out_valid", out_valid, 0);
    check("rst async sum", sum, 0);
    check("rst async carry_out", carry_out, 0);
    check("rst async in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      check("post-rst no out_valid", out_valid, 0);
    end
    run_op(8'd1, 8'd2, 8'd3, 1'b0, "post-rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
